// File: rtl/lc3_io_pkg.sv
// Shared LC-3 I/O definitions: receiver FSM states, KBSR bit positions and
// keyboard device addresses.
package lc3_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } rx_state_t;

  localparam int KBSR_READY = 15;
  localparam int KBSR_OVRN  = 14;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;

endpackage

// File: rtl/uart_rx_kbd_if.sv
// Keyboard-side bus of the UART receiver: serial line and CPU read strobe in,
// memory-mapped KBSR/KBDR and status pulses out.
interface uart_rx_kbd_if;
  logic        i_Rx_Serial;
  logic        i_KBDR_Rd;
  logic [15:0] o_KBSR;
  logic [15:0] o_KBDR;
  logic        o_Rx_DV;
  logic        o_Frame_Err;
  logic        o_Rx_Active;

  modport master (
    output i_Rx_Serial, i_KBDR_Rd,
    input  o_KBSR, o_KBDR, o_Rx_DV, o_Frame_Err, o_Rx_Active
  );

  modport slave (
    input  i_Rx_Serial, i_KBDR_Rd,
    output o_KBSR, o_KBDR, o_Rx_DV, o_Frame_Err, o_Rx_Active
  );
endinterface

// File: rtl/uart_rx_kbd_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both stages reset
// to RST_VAL so an idle-high line does not look like a start edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_D,
  output logic o_Q
);

  logic meta;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      meta <= RST_VAL;
      o_Q  <= RST_VAL;
    end else begin
      meta <= i_D;
      o_Q  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_kbd.sv
// 8N1 UART receiver feeding the LC-3 keyboard device: received bytes land in
// KBDR with a ready flag in KBSR that the CPU clears by reading KBDR.
module uart_rx_kbd
  import lc3_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic          i_Clock,
  input  logic          i_Reset_n,
  uart_rx_kbd_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  rx_state_t     state;
  logic [CW-1:0] count;
  logic [2:0]    idx;
  logic [7:0]    shift_reg;
  logic [7:0]    rx_byte;
  logic          ready;
  logic          ovrn;
  logic          rx_dv;
  logic          frame_err;
  logic          rx_active;
  logic          rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_D       (bus.i_Rx_Serial),
    .o_Q       (rx_s)
  );

  assign bus.o_KBSR      = {ready, ovrn, 14'b0};
  assign bus.o_KBDR      = {8'h00, rx_byte};
  assign bus.o_Rx_DV     = rx_dv;
  assign bus.o_Frame_Err = frame_err;
  assign bus.o_Rx_Active = rx_active;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      idx       <= '0;
      shift_reg <= '0;
      rx_byte   <= '0;
      ready     <= 1'b0;
      ovrn      <= 1'b0;
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      rx_active <= 1'b0;
    end else begin
      rx_dv     <= 1'b0;
      frame_err <= 1'b0;
      if (bus.i_KBDR_Rd) begin
        ready <= 1'b0;
        ovrn  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          count <= '0;
          idx   <= '0;
          if (!rx_s) state <= ST_START;
        end
        ST_START: begin
          if (count == CNT_HALF) begin
            count <= '0;
            if (!rx_s) begin
              state     <= ST_DATA;
              rx_active <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_DATA: begin
          if (count == CNT_LAST) begin
            count          <= '0;
            shift_reg[idx] <= rx_s;
            if (idx == 3'd7) state <= ST_STOP;
            else             idx   <= idx + 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_STOP: begin
          if (count == CNT_LAST) begin
            count <= '0;
            state <= ST_CLEANUP;
            if (rx_s) begin
              // A write coinciding with a CPU read wins, but leaves no overrun.
              rx_byte <= shift_reg;
              rx_dv   <= 1'b1;
              ready   <= 1'b1;
              ovrn    <= bus.i_KBDR_Rd ? 1'b0 : (ovrn | ready);
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_CLEANUP: begin
          rx_active <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_kbd.sv
// Directed and randomized frames against a byte-level model of the keyboard
// registers (ready/overrun/last byte), with bit-accurate serial stimulus.
module tb_uart_rx_kbd;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_rx_kbd_if bus ();

  uart_rx_kbd #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock   (clk),
    .i_Reset_n (rst_n),
    .bus       (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int act_cnt = 0;

  always @(negedge clk) begin
    if (bus.o_Rx_DV === 1'b1)     dv_cnt  <= dv_cnt + 1;
    if (bus.o_Frame_Err === 1'b1) fe_cnt  <= fe_cnt + 1;
    if (bus.o_Rx_Active === 1'b1) act_cnt <= act_cnt + 1;
  end

  logic       m_ready, m_ovrn;
  logic [7:0] m_byte;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_kbsr"}, bus.o_KBSR, {m_ready, m_ovrn, 14'b0});
    chk({tag, "_kbdr"}, bus.o_KBDR, {8'h00, m_byte});
  endtask

  task automatic drive_bit(input logic v);
    bus.i_Rx_Serial = v;
    repeat (CPB) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    bus.i_Rx_Serial = 1'b1;
    repeat (CPB + 4) begin @(posedge clk); #1; end
  endtask

  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (stop) begin
      m_ovrn  = m_ovrn | m_ready;
      m_ready = 1'b1;
      m_byte  = b;
    end
  endtask

  task automatic run_frame(input logic [7:0] b, input logic stop, input string tag);
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(b, stop);
    model_rx(b, stop);
    chk({tag, "_dv"}, 16'(dv_cnt - dv0), stop ? 16'd1 : 16'd0);
    chk({tag, "_ferr"}, 16'(fe_cnt - fe0), stop ? 16'd0 : 16'd1);
    chk_regs(tag);
  endtask

  task automatic do_read(input string tag);
    bus.i_KBDR_Rd = 1'b1;
    @(posedge clk); #1;
    bus.i_KBDR_Rd = 1'b0;
    m_ready = 1'b0;
    m_ovrn  = 1'b0;
    chk_regs(tag);
  endtask

  initial begin
    int dv0, fe0, a0;
    logic [7:0] rb;
    logic       rs;

    rst_n = 1'b0;
    bus.i_Rx_Serial = 1'b1;
    bus.i_KBDR_Rd   = 1'b0;
    m_ready = 1'b0; m_ovrn = 1'b0; m_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_regs("reset");
    chk("reset_flags", {13'b0, bus.o_Rx_DV, bus.o_Frame_Err, bus.o_Rx_Active}, 16'h0000);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    run_frame(8'h41, 1'b1, "t1_41");
    do_read("t2_read");

    run_frame(8'h55, 1'b1, "t3_55");
    run_frame(8'hAA, 1'b1, "t3_aa");
    chk("t3_ovrn_kbsr", bus.o_KBSR, 16'hC000);
    do_read("t3_read");

    run_frame(8'h3C, 1'b0, "t4_badstop");
    run_frame(8'h7E, 1'b1, "t4_7e");

    // glitch on idle line
    dv0 = dv_cnt; fe0 = fe_cnt; a0 = act_cnt;
    bus.i_Rx_Serial = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    bus.i_Rx_Serial = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("t5_dv", 16'(dv_cnt - dv0), 16'd0);
    chk("t5_ferr", 16'(fe_cnt - fe0), 16'd0);
    chk("t5_active", 16'(act_cnt - a0), 16'd0);
    chk_regs("t5");

    // read strobe landing on the write edge of 8'h5A while 8'h7E is unread
    fork
      send_frame(8'h5A, 1'b1);
      begin
        repeat (9 * CPB + 6) @(posedge clk);
        #1 bus.i_KBDR_Rd = 1'b1;
        @(posedge clk);
        #1 bus.i_KBDR_Rd = 1'b0;
        chk("coinc_dv", {15'b0, bus.o_Rx_DV}, 16'h0001);
        chk("coinc_kbsr", bus.o_KBSR, 16'h8000);
      end
    join
    m_ready = 1'b1; m_ovrn = 1'b0; m_byte = 8'h5A;
    chk_regs("coinc_after");

    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      run_frame(rb, rs, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) do_read($sformatf("rnd%0d_rd", i));
    end

    // reset in the middle of the data bits of 8'hFF, with a byte pending
    run_frame(8'h99, 1'b1, "t6_pre");
    bus.i_Rx_Serial = 1'b0;
    repeat (CPB) begin @(posedge clk); #1; end
    bus.i_Rx_Serial = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("t6_active_mid", {15'b0, bus.o_Rx_Active}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    m_ready = 1'b0; m_ovrn = 1'b0; m_byte = 8'h00;
    chk_regs("t6_rst");
    chk("t6_rst_flags", {13'b0, bus.o_Rx_DV, bus.o_Frame_Err, bus.o_Rx_Active}, 16'h0000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    run_frame(8'h0D, 1'b1, "t6_0d");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
